// File: rtl/led_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// led_scan_driver_pkg
//
// Purpose : Shared constants for the LED matrix scan path. Holds the matrix
//           geometry, the pixel width, the scan FSM state encodings and small
//           one-hot helpers used by the scanner and its line buffer.
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package led_scan_driver_pkg;

    // Matrix geometry and pixel depth.
    localparam int NUM_ROWS     = 8;
    localparam int NUM_COLS     = 8;
    localparam int PIX_W        = 4;

    // One PWM slot per intensity step; intensity N is lit for N of these.
    localparam int NUM_SLOTS    = 1 << PIX_W;

    // One address cycle per column plus one trailing cycle to catch the
    // last registered read.
    localparam int FETCH_CYCLES = NUM_COLS + 1;

    localparam int ROW_W        = $clog2(NUM_ROWS);
    localparam int COL_W        = $clog2(NUM_COLS);

    // Scan FSM state encodings.
    localparam logic [1:0] SCAN_IDLE    = 2'd0;
    localparam logic [1:0] SCAN_FETCH   = 2'd1;
    localparam logic [1:0] SCAN_BLANK   = 2'd2;
    localparam logic [1:0] SCAN_DISPLAY = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
        return NUM_ROWS'(1) << idx;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [COL_W-1:0] idx);
        return NUM_COLS'(1) << idx;
    endfunction

endpackage : led_scan_driver_pkg

// File: rtl/led_scan_driver_line_pwm.sv
// -----------------------------------------------------------------------------
// led_line_pwm
//
// Purpose : Line buffer for the row currently on display plus the PWM
//           comparator. Holds one intensity per column, loaded one column at
//           a time during FETCH, and turns the current PWM slot number into
//           raw (active-high) column enables: a column is on while its
//           intensity is strictly greater than the slot number, so intensity
//           0 never lights and intensity 15 lights for 15 of 16 slots.
//
// Ports   : clk        system clock
//           rst_n      asynchronous active-low reset (clears the buffer)
//           wr_en      load strobe for one buffer entry
//           wr_idx     column index being loaded
//           wr_data    intensity to store
//           slot_i     current PWM slot, 0..15
//           col_raw_o  active-high column enables for the current slot
// -----------------------------------------------------------------------------
module led_line_pwm
    import led_scan_driver_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [COL_W-1:0]     wr_idx,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic [PIX_W-1:0]     slot_i,
    output logic [NUM_COLS-1:0]  col_raw_o
);

    logic [PIX_W-1:0] line_q [NUM_COLS];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    // NOTE: this small buffer is reset on purpose: the scanner's reset state
    // defines an all-zero line, and an un-reset buffer would show X-driven
    // columns if DISPLAY were ever reached before the first full FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                line_q[i] <= '0;
            end
        end else if (wr_en) begin
            line_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            col_raw_o[c] = (line_q[c] > slot_i);
        end
    end

endmodule : led_line_pwm

// File: rtl/led_scan_driver.sv
// -----------------------------------------------------------------------------
// led_scan_driver
//
// Purpose : Scans an 8x8 LED matrix row by row with 16-level PWM. For each row
//           it reads the eight pixel intensities out of the frame RAM (FETCH),
//           holds all lines dark for a dead time (BLANK), then lights the row
//           for 16 PWM slots (DISPLAY). Rows 0..7 repeat while en is high; en
//           is only looked at on row boundaries (and in IDLE).
//
// Timing  : row period   = 9 + BLANK_CYCLES + 16*SLOT_CYCLES clocks
//           frame period = 8 row periods
//
// Ports   : clk          system clock
//           rst_n        asynchronous active-low reset
//           en           scan enable
//           rd_data      pixel intensity, valid one cycle after the address
//           rd_row       one-hot RAM read row address (registered)
//           rd_col       one-hot RAM read column address (registered)
//           rd_req       high while the scanner owns the RAM read port
//           row_drv      one-hot row enable, active high
//           col_drv      column enables, inverted when COL_ACTIVE_LOW=1
//           frame_start  one-cycle pulse in the first FETCH cycle of row 0
//
// Parameters: SLOT_CYCLES    clocks per PWM slot (>=1)
//             BLANK_CYCLES   dead-time clocks before each row is lit (>=1)
//             COL_ACTIVE_LOW 1 = column lines are active low
// -----------------------------------------------------------------------------
module led_scan_driver
    import led_scan_driver_pkg::*;
#(
    parameter int SLOT_CYCLES    = 64,
    parameter int BLANK_CYCLES   = 8,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [PIX_W-1:0]     rd_data,
    output logic [NUM_ROWS-1:0]  rd_row,
    output logic [NUM_COLS-1:0]  rd_col,
    output logic                 rd_req,
    output logic [NUM_ROWS-1:0]  row_drv,
    output logic [NUM_COLS-1:0]  col_drv,
    output logic                 frame_start
);

    // One shared cycle counter serves FETCH, BLANK and each PWM slot, so it
    // must hold the largest terminal count of the three.
    localparam int CNT_MAX = max3(SLOT_CYCLES, BLANK_CYCLES, FETCH_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    FETCH_LAST = CNT_W'(FETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ADDR_CYCLES = CNT_W'(NUM_COLS);
    localparam logic [PIX_W-1:0]    LAST_SLOT  = PIX_W'(NUM_SLOTS - 1);
    localparam logic [NUM_COLS-1:0] COL_POL    = {NUM_COLS{COL_ACTIVE_LOW}};

    // ---------------------------------------------------------------- state
    logic [1:0]          state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [PIX_W-1:0]    slot_q,    slot_d;
    logic [ROW_W-1:0]    row_idx_q, row_idx_d;

    // ------------------------------------------------------ output registers
    logic [NUM_ROWS-1:0] rd_row_q,      rd_row_d;
    logic [NUM_COLS-1:0] rd_col_q,      rd_col_d;
    logic                rd_req_q,      rd_req_d;
    logic                frame_start_q, frame_start_d;
    logic [NUM_ROWS-1:0] row_drv_q,     row_drv_d;
    logic [NUM_COLS-1:0] col_drv_q,     col_drv_d;

    // ----------------------------------------------------- line buffer / PWM
    logic                line_wr_en;
    logic [COL_W-1:0]    line_wr_idx;
    logic [NUM_COLS-1:0] col_raw;

    // The read address for column k goes out in FETCH cycle k, so its data
    // arrives in cycle k+1 and is written to column k-1 of the cycle index.
    assign line_wr_en  = (state_q == SCAN_FETCH) && (cnt_q != '0);
    assign line_wr_idx = COL_W'(cnt_q - CNT_W'(1));

    led_line_pwm u_line_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (line_wr_en),
        .wr_idx    (line_wr_idx),
        .wr_data   (rd_data),
        .slot_i    (slot_q),
        .col_raw_o (col_raw)
    );

    // ------------------------------------------------------ scan sequencing
    always_comb begin
        // NOTE: every signal written here gets a default first; without it a
        // path that skips an assignment would infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        slot_d        = slot_q;
        row_idx_d     = row_idx_q;
        frame_start_d = 1'b0;

        case (state_q)
            SCAN_IDLE: begin
                cnt_d     = '0;
                slot_d    = '0;
                row_idx_d = '0;
                if (en) begin
                    // Scanning always resumes at row 0, i.e. a new frame.
                    state_d       = SCAN_FETCH;
                    frame_start_d = 1'b1;
                end
            end

            SCAN_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    state_d = SCAN_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SCAN_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SCAN_DISPLAY;
                    cnt_d   = '0;
                    slot_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SCAN_DISPLAY: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (slot_q == LAST_SLOT) begin
                        // Row boundary: the only point where en is honoured.
                        slot_d = '0;
                        if (en) begin
                            state_d       = SCAN_FETCH;
                            row_idx_d     = row_idx_q + ROW_W'(1);
                            frame_start_d = (row_idx_q == ROW_W'(NUM_ROWS - 1));
                        end else begin
                            state_d   = SCAN_IDLE;
                            row_idx_d = '0;
                        end
                    end else begin
                        slot_d = slot_q + PIX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = SCAN_IDLE;
                cnt_d     = '0;
                slot_d    = '0;
                row_idx_d = '0;
            end
        endcase
    end

    // -------------------------------------------------- RAM read addressing
    // These are computed from the next state so the registered address is
    // already valid in the first cycle of FETCH (k=0), which keeps the RAM
    // read latency at exactly one cycle. Past the last column the address is
    // simply held; in IDLE it parks at row 0 / column 0.
    always_comb begin
        rd_req_d = (state_d == SCAN_FETCH);
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        if ((state_d == SCAN_FETCH) && (cnt_d < ADDR_CYCLES)) begin
            rd_row_d = row_onehot(row_idx_d);
            rd_col_d = col_onehot(COL_W'(cnt_d));
        end else if (state_d == SCAN_IDLE) begin
            rd_row_d = row_onehot('0);
            rd_col_d = col_onehot('0);
        end
    end

    // ------------------------------------------------------- matrix drivers
    // Driven from the current state, so the lines follow the counters one
    // cycle later. Outside DISPLAY everything is dark, which gives the BLANK
    // dead time and keeps rows and columns from overlapping in IDLE.
    always_comb begin
        row_drv_d = '0;
        col_drv_d = COL_POL;
        if (state_q == SCAN_DISPLAY) begin
            row_drv_d = row_onehot(row_idx_q);
            col_drv_d = col_raw ^ COL_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN_IDLE;
            cnt_q         <= '0;
            slot_q        <= '0;
            row_idx_q     <= '0;
            rd_row_q      <= row_onehot('0);
            rd_col_q      <= col_onehot('0);
            rd_req_q      <= 1'b0;
            frame_start_q <= 1'b0;
            row_drv_q     <= '0;
            col_drv_q     <= COL_POL;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            row_idx_q     <= row_idx_d;
            rd_row_q      <= rd_row_d;
            rd_col_q      <= rd_col_d;
            rd_req_q      <= rd_req_d;
            frame_start_q <= frame_start_d;
            row_drv_q     <= row_drv_d;
            col_drv_q     <= col_drv_d;
        end
    end

    assign rd_row      = rd_row_q;
    assign rd_col      = rd_col_q;
    assign rd_req      = rd_req_q;
    assign frame_start = frame_start_q;
    assign row_drv     = row_drv_q;
    assign col_drv     = col_drv_q;

endmodule : led_scan_driver
